// File: rtl/transformer_pkg.sv
// transformer_pkg
//   Shared definitions for the transformer accelerator sequencer:
//   default token/select widths, sequencer state encoding, sticky-error
//   bit positions and symbolic names for the datapath stages that
//   block_sel walks through.
package transformer_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;

  // Bit positions inside the sticky err vector.
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_DROP    = 1;

  // Datapath stage order; block_sel counts through these values.
  localparam int BLK_EMBED = 0;
  localparam int BLK_ATTN  = 1;
  localparam int BLK_FFN   = 2;
  localparam int BLK_NORM  = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

endpackage

// File: rtl/ctrl_watchdog.sv
// ctrl_watchdog
//   Counts consecutive enabled cycles and raises a one-cycle timeout
//   indication on the TIMEOUT-th enabled cycle since the last clear.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       restart the count from zero (wins over enable)
//   enable      count this cycle
//   timeout     high during the TIMEOUT-th enabled cycle after clear
module ctrl_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);
  import transformer_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The count equals the number of enabled cycles already elapsed, so the
  // cycle in which it reads TIMEOUT-1 is the TIMEOUT-th one.
  assign timeout = enable && (cnt_q == LIMIT);

  // Freeze once the limit is reached so the counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/transformer_seq_ctrl.sv
// transformer_seq_ctrl
//   Top-level sequencer for the transformer accelerator. Loads one
//   sequence of SEQ_LEN tokens into the input buffer, runs the datapath
//   stages 0..NUM_BLOCKS-1 with a start/done handshake each, forwards the
//   final stage's SEQ_LEN output beats and then pulses done. A watchdog
//   aborts a stage that never answers. Every output is registered.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   data_in, data_in_valid, in_ready    input token stream
//   buf_wr_en, buf_wr_addr, buf_wr_data input-buffer write port
//   block_sel, blk_start, blk_done      stage select and handshake
//   dp_out, dp_out_valid                final-stage output stream
//   data_out, data_out_valid            forwarded result stream
//   done                                one-cycle end-of-sequence pulse
//   err                                 sticky [0] timeout, [1] token dropped
module transformer_seq_ctrl #(
  parameter int DATA_W     = transformer_pkg::DATA_W,
  parameter int SEQ_LEN    = 30,
  parameter int NUM_BLOCKS = 4,
  parameter int SEL_W      = transformer_pkg::SEL_W,
  parameter int TIMEOUT    = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       data_in_valid,
  output logic                       in_ready,
  output logic                       buf_wr_en,
  output logic [$clog2(SEQ_LEN)-1:0] buf_wr_addr,
  output logic [DATA_W-1:0]          buf_wr_data,
  output logic [SEL_W-1:0]           block_sel,
  output logic                       blk_start,
  input  logic                       blk_done,
  input  logic [DATA_W-1:0]          dp_out,
  input  logic                       dp_out_valid,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_out_valid,
  output logic                       done,
  output logic [1:0]                 err
);
  import transformer_pkg::*;

  localparam int CNT_W = $clog2(SEQ_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SEQ_LEN - 1);
  localparam logic [SEL_W-1:0] LAST_BLK = SEL_W'(NUM_BLOCKS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [SEL_W-1:0]   block_sel_q, block_sel_d;
  logic [1:0]         err_q, err_d;

  logic               in_ready_q, in_ready_d;
  logic               buf_wr_en_q, buf_wr_en_d;
  logic [CNT_W-1:0]   buf_wr_addr_q, buf_wr_addr_d;
  logic [DATA_W-1:0]  buf_wr_data_q, buf_wr_data_d;
  logic               blk_start_q, blk_start_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_out_valid_q, data_out_valid_d;
  logic               done_q, done_d;

  logic               accept;
  logic               drop;
  logic               wd_timeout;

  // Acceptance is judged against the in_ready actually presented to the
  // source, so a token is either written or flagged as dropped, never both.
  assign accept = data_in_valid && in_ready_q;
  assign drop   = data_in_valid && !in_ready_q;

  // The watchdog restarts while a stage is being started, so it measures
  // only the cycles spent waiting on that stage.
  ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == ST_START),
    .enable  (state_q == ST_WAIT),
    .timeout (wd_timeout)
  );

  // State and counter registers plus the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      wr_cnt_q         <= '0;
      out_cnt_q        <= '0;
      block_sel_q      <= '0;
      err_q            <= '0;
      in_ready_q       <= 1'b0;
      buf_wr_en_q      <= 1'b0;
      buf_wr_addr_q    <= '0;
      buf_wr_data_q    <= '0;
      blk_start_q      <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_cnt_q         <= wr_cnt_d;
      out_cnt_q        <= out_cnt_d;
      block_sel_q      <= block_sel_d;
      err_q            <= err_d;
      in_ready_q       <= in_ready_d;
      buf_wr_en_q      <= buf_wr_en_d;
      buf_wr_addr_q    <= buf_wr_addr_d;
      buf_wr_data_q    <= buf_wr_data_d;
      blk_start_q      <= blk_start_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      done_q           <= done_d;
    end
  end

  // Next-state logic. Counters are cleared whenever their state is left,
  // so none of them ever wraps. A blk_done in the same cycle as the
  // watchdog expiry still counts as a completed stage.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    out_cnt_d   = out_cnt_q;
    block_sel_d = block_sel_q;
    err_d       = err_q;

    if (drop) begin
      err_d[ERR_DROP] = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          if (wr_cnt_q == LAST_IDX) begin
            state_d     = ST_START;
            wr_cnt_d    = '0;
            block_sel_d = '0;
          end else begin
            state_d  = ST_LOAD;
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (blk_done) begin
          if (block_sel_q < LAST_BLK) begin
            block_sel_d = block_sel_q + 1'b1;
            state_d     = ST_START;
          end else begin
            state_d = ST_OUTPUT;
          end
        end else if (wd_timeout) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          block_sel_d        = '0;
          state_d            = ST_IDLE;
        end
      end
      ST_OUTPUT: begin
        if (dp_out_valid) begin
          if (out_cnt_q == LAST_IDX) begin
            state_d     = ST_FIN;
            out_cnt_d   = '0;
            block_sel_d = '0;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d     = ST_IDLE;
        wr_cnt_d    = '0;
        out_cnt_d   = '0;
        block_sel_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic. Flags derived from state_d line up with the state the
  // machine is in while they are visible; the data paths capture the
  // current inputs and hold their last value when idle.
  always_comb begin
    in_ready_d       = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    blk_start_d      = (state_d == ST_START);
    done_d           = (state_d == ST_FIN);

    buf_wr_en_d      = accept;
    buf_wr_addr_d    = buf_wr_addr_q;
    buf_wr_data_d    = buf_wr_data_q;
    if (accept) begin
      buf_wr_addr_d = wr_cnt_q;
      buf_wr_data_d = data_in;
    end

    data_out_valid_d = (state_q == ST_OUTPUT) && dp_out_valid;
    data_out_d       = data_out_q;
    if (data_out_valid_d) begin
      data_out_d = dp_out;
    end
  end

  assign in_ready       = in_ready_q;
  assign buf_wr_en      = buf_wr_en_q;
  assign buf_wr_addr    = buf_wr_addr_q;
  assign buf_wr_data    = buf_wr_data_q;
  assign block_sel      = block_sel_q;
  assign blk_start      = blk_start_q;
  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_transformer_seq_ctrl.sv
// tb_transformer_seq_ctrl
//   Directed bench for transformer_seq_ctrl built with a 64-cycle watchdog.
//   Inputs change 1 time unit after each rising edge and outputs are
//   compared at the same point, so every value seen is the settled result
//   of the preceding edge.
module tb_transformer_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_in_valid;
  logic        in_ready;
  logic        buf_wr_en;
  logic [4:0]  buf_wr_addr;
  logic [15:0] buf_wr_data;
  logic [2:0]  block_sel;
  logic        blk_start;
  logic        blk_done;
  logic [15:0] dp_out;
  logic        dp_out_valid;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        done;
  logic [1:0]  err;

  int checkCnt;
  int passCnt;

  transformer_seq_ctrl #(
    .DATA_W     (16),
    .SEQ_LEN    (30),
    .NUM_BLOCKS (4),
    .SEL_W      (3),
    .TIMEOUT    (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .in_ready       (in_ready),
    .buf_wr_en      (buf_wr_en),
    .buf_wr_addr    (buf_wr_addr),
    .buf_wr_data    (buf_wr_data),
    .block_sel      (block_sel),
    .blk_start      (blk_start),
    .blk_done       (blk_done),
    .dp_out         (dp_out),
    .dp_out_valid   (dp_out_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .done           (done),
    .err            (err)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-derived expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCnt++;
    assert (observed === expected) passCnt++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Drive all data-side inputs at once.
  task automatic applyStimulus(input logic vld, input logic [15:0] din, input logic bdone,
                               input logic dvld, input logic [15:0] dout);
    data_in_valid = vld;
    data_in       = din;
    blk_done      = bdone;
    dp_out_valid  = dvld;
    dp_out        = dout;
  endtask

  // Advance to just after the next rising edge.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Stream 30 tokens base+0..base+29, optionally idling a cycle between
  // them. Ends in the START cycle of stage 0.
  task automatic loadTokens(input logic [15:0] base, input bit withGaps);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, base + 16'(i), 1'b0, 1'b0, 16'h0000);
      waitCycle();
      checkOutput("wr_en", buf_wr_en, 1'b1);
      checkOutput("wr_addr", buf_wr_addr, i);
      checkOutput("wr_data", buf_wr_data, base + 16'(i));
      if (i < 29) begin
        checkOutput("in_ready_load", in_ready, 1'b1);
      end else begin
        checkOutput("in_ready_fall", in_ready, 1'b0);
        checkOutput("first_start", blk_start, 1'b1);
        checkOutput("first_sel", block_sel, 3'd0);
      end
      data_in_valid = 1'b0;
      if (withGaps && i < 29) begin
        waitCycle();
        checkOutput("gap_no_wr", buf_wr_en, 1'b0);
        checkOutput("gap_ready", in_ready, 1'b1);
      end
    end
  endtask

  // Answer nBlocks stages with blk_done five cycles after each blk_start.
  // Stray dp_out_valid during WAIT must not leak out; optionally a token
  // is offered during the first WAIT and must be dropped.
  task automatic runBlocks(input int nBlocks, input bit doDrop);
    for (int b = 0; b < nBlocks; b++) begin
      checkOutput("stage_start", blk_start, 1'b1);
      checkOutput("stage_sel", block_sel, b);
      for (int k = 1; k <= 5; k++) begin
        waitCycle();
        checkOutput("start_single", blk_start, 1'b0);
        if (doDrop && b == 0 && k == 1) begin
          data_in_valid = 1'b1;
          data_in       = 16'hDEAD;
        end
        if (doDrop && b == 0 && k == 2) begin
          checkOutput("drop_err", err, 2'b10);
          checkOutput("drop_no_wr", buf_wr_en, 1'b0);
          data_in_valid = 1'b0;
        end
        if (k == 3) begin
          dp_out_valid = 1'b1;
          dp_out       = 16'hBEEF;
        end
        if (k == 4) begin
          checkOutput("wait_dp_ignored", data_out_valid, 1'b0);
          dp_out_valid = 1'b0;
        end
        if (k == 5) begin
          blk_done = 1'b1;
        end
      end
      waitCycle();
      blk_done = 1'b0;
    end
  endtask

  // Feed 30 output beats, expect them one cycle later, a single done on
  // the last one, and an extra beat afterwards to be ignored.
  task automatic runOutput(input logic [15:0] base, input logic [1:0] expErr);
    checkOutput("out_sel_held", block_sel, 3'd3);
    checkOutput("out_no_start", blk_start, 1'b0);
    for (int j = 0; j < 30; j++) begin
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, base + 16'(j));
      waitCycle();
      checkOutput("out_valid", data_out_valid, 1'b1);
      checkOutput("out_data", data_out, base + 16'(j));
      if (j < 29) begin
        checkOutput("done_early", done, 1'b0);
      end else begin
        checkOutput("done_pulse", done, 1'b1);
        checkOutput("fin_sel", block_sel, 3'd0);
        checkOutput("fin_ready", in_ready, 1'b0);
      end
    end
    dp_out = 16'hFFFF;
    waitCycle();
    dp_out_valid = 1'b0;
    checkOutput("extra_beat_ignored", data_out_valid, 1'b0);
    checkOutput("done_once", done, 1'b0);
    checkOutput("idle_ready", in_ready, 1'b1);
    checkOutput("seq_err", err, expErr);
  endtask

  initial begin
    checkCnt = 0;
    passCnt  = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

    // Reset values.
    waitCycle();
    waitCycle();
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_sel", block_sel, 3'd0);
    checkOutput("rst_err", err, 2'b00);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_wr_en", buf_wr_en, 1'b0);
    checkOutput("rst_out_valid", data_out_valid, 1'b0);
    rst_n = 1'b1;
    waitCycle();
    checkOutput("post_rst_ready", in_ready, 1'b1);

    // Back-to-back tokens, full stage sequence, output and done.
    $display("[TB] sequence with consecutive tokens");
    loadTokens(16'h0001, 1'b0);
    runBlocks(4, 1'b0);
    runOutput(16'hA000, 2'b00);

    // Every-other-cycle tokens plus a token offered during WAIT.
    $display("[TB] sequence with token gaps and a dropped token");
    loadTokens(16'h0100, 1'b1);
    runBlocks(4, 1'b1);
    runOutput(16'hB000, 2'b10);

    rst_n = 1'b0;
    waitCycle();
    rst_n = 1'b1;
    waitCycle();
    checkOutput("err_cleared", err, 2'b00);

    // Stage 2 never answers: 64 WAIT cycles, then abort to IDLE.
    $display("[TB] stage timeout");
    loadTokens(16'h0200, 1'b0);
    runBlocks(2, 1'b0);
    checkOutput("to_sel", block_sel, 3'd2);
    for (int k = 1; k <= 64; k++) begin
      waitCycle();
    end
    checkOutput("to_last_wait_err", err, 2'b00);
    checkOutput("to_last_wait_sel", block_sel, 3'd2);
    waitCycle();
    checkOutput("to_err", err, 2'b01);
    checkOutput("to_sel_clear", block_sel, 3'd0);
    checkOutput("to_ready", in_ready, 1'b1);
    checkOutput("to_no_done", done, 1'b0);
    waitCycle();
    checkOutput("to_still_no_done", done, 1'b0);

    // Reset during output beat 10, then a clean sequence.
    $display("[TB] reset during output");
    loadTokens(16'h0300, 1'b0);
    runBlocks(4, 1'b0);
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hC000 + 16'(j));
      waitCycle();
      checkOutput("pre_rst_data", data_out, 16'hC000 + 16'(j));
    end
    dp_out = 16'hC00A;
    rst_n  = 1'b0;
    #1;
    checkOutput("async_out_valid", data_out_valid, 1'b0);
    checkOutput("async_data", data_out, 16'h0000);
    checkOutput("async_sel", block_sel, 3'd0);
    checkOutput("async_err", err, 2'b00);
    checkOutput("async_ready", in_ready, 1'b0);
    checkOutput("async_done", done, 1'b0);
    waitCycle();
    rst_n        = 1'b1;
    dp_out_valid = 1'b0;
    waitCycle();
    checkOutput("rst2_ready", in_ready, 1'b1);
    checkOutput("rst2_no_done", done, 1'b0);
    loadTokens(16'h0400, 1'b0);
    runBlocks(4, 1'b0);
    runOutput(16'hD000, 2'b00);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/transformer_seq_ctrl.md
Name: transformer_seq_ctrl

Overview:
- Top-level sequencer for the transformer accelerator.
- Accepts one sequence of SEQ_LEN 16-bit tokens into the input buffer.
- Steps block_sel through NUM_BLOCKS datapath stages using a start/done handshake per stage.
- Forwards the final stage's output stream, then pulses done; a watchdog flags hung stages.

Parameters:
- DATA_W, 16, token width.
- SEQ_LEN, 30, tokens per sequence, on both input and output.
- NUM_BLOCKS, 4, datapath stages, selected as 0..NUM_BLOCKS-1.
- SEL_W, 3, block_sel width; NUM_BLOCKS <= 2**SEL_W.
- TIMEOUT, 4096, maximum cycles in WAIT before error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_W  input token.
- data_in_valid  in  1  token valid.
- in_ready  out  1  controller accepting tokens.
- buf_wr_en  out  1  input-buffer write strobe.
- buf_wr_addr  out  $clog2(SEQ_LEN)  write address.
- buf_wr_data  out  DATA_W  write data.
- block_sel  out  SEL_W  active datapath stage.
- blk_start  out  1  one-cycle stage start pulse.
- blk_done  in  1  stage complete, one-cycle pulse.
- dp_out  in  DATA_W  final-stage output token.
- dp_out_valid  in  1  final-stage output valid.
- data_out  out  DATA_W  forwarded result token.
- data_out_valid  out  1  result valid.
- done  out  1  one-cycle end-of-sequence pulse.
- err  out  2  sticky: [0] stage timeout, [1] token dropped.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all counters 0, block_sel=0, all outputs 0, err=0. Reset mid-operation aborts immediately; no done is issued.
- All outputs are registered.
- in_ready=1 only in IDLE and LOAD.
- FSM states: IDLE, LOAD, START, WAIT, OUTPUT, FIN.
- IDLE: data_in_valid=1 writes token 0 and moves to LOAD.
- LOAD: each valid token is written at wr_cnt; wr_cnt then increments.
- After the write of address SEQ_LEN-1: go to START, block_sel=0, in_ready=0 from the next cycle.
- Write latency: the token sampled at edge N appears on buf_wr_en/addr/data during cycle N+1.
- Gaps in data_in_valid are allowed; wr_cnt holds.
- START: blk_start=1 for exactly one cycle, then WAIT; the watchdog clears on entry to WAIT.
- WAIT: blk_done is sampled only here, earliest the cycle after blk_start.
  - If block_sel < NUM_BLOCKS-1: block_sel increments, go to START.
  - Otherwise: go to OUTPUT with block_sel held.
- WAIT timeout: TIMEOUT cycles without blk_done sets err[0], block_sel=0, go to IDLE.
- blk_done outside WAIT is ignored.
- OUTPUT: data_out/data_out_valid = dp_out/dp_out_valid registered, 1-cycle latency; out_cnt counts beats.
- Beat SEQ_LEN-1 leads to FIN, and further dp_out_valid is ignored.
- FIN: done=1 for one cycle, block_sel=0, counters=0, go to IDLE. A new sequence may start the following cycle.
- Token drop: data_in_valid=1 while in_ready=0 sets err[1]; the token is discarded.
- Error clearing: err is cleared only by reset.
- Simultaneous events: a valid on the last LOAD token is accepted normally. dp_out_valid during START/WAIT is ignored.
- Widths: counters are $clog2(SEQ_LEN) bits and the watchdog is $clog2(TIMEOUT+1) bits. No wrap: counters clear on state exit.

Decomposition:
- transformer_pkg holds:
  - state encoding localparams (ST_IDLE..ST_FIN, 3 bits);
  - DATA_W, SEL_W;
  - err bit indices;
  - block index constants (BLK_EMBED=0, BLK_ATTN=1, BLK_FFN=2, BLK_NORM=3).
- Sub-module ctrl_watchdog: clear/enable inputs, timeout pulse output, parameter TIMEOUT.

Test Plan:
- 30 consecutive tokens 0x0001..0x001E:
  - buf_wr_addr 0..29 with matching data, one cycle delayed;
  - in_ready falls after the 30th;
  - blk_start with block_sel=0.
- blk_done returned 5 cycles after each blk_start:
  - block_sel steps 0,1,2,3, each with a single blk_start;
  - then 30 dp_out_valid beats appear on data_out 1 cycle later;
  - done pulses once, block_sel returns to 0.
- Tokens with valid gaps (valid every other cycle) -> still exactly 30 writes, addresses contiguous.
- Token valid during WAIT -> err=2'b10, no buffer write; sequence completes normally.
- blk_done withheld after block_sel=2, TIMEOUT=64 -> after 64 WAIT cycles err[0]=1, state IDLE, no done.
- rst_n low for one cycle during OUTPUT beat 10 -> all outputs 0 immediately; a following 30-token sequence completes with a correct done.
